// File: rtl/multi_operand_adder_pipe.sv
// Two-stage N-operand unsigned adder: CSA reduction, then carry-propagate add.
// Define MOA_ACCUM_EN to accumulate beats into one total per in_last group.
module multi_operand_adder_pipe #(
   parameter int WIDTH     = 19,
   parameter int N_OPS     = 3,
   parameter int ACC_GUARD = 8,
`ifdef MOA_ACCUM_EN
   localparam bit ACC_EN   = 1'b1,
`else
   localparam bit ACC_EN   = 1'b0,
`endif
   localparam int OUT_W    = WIDTH + $clog2(N_OPS),
   localparam int SUM_W    = OUT_W + (ACC_EN ? ACC_GUARD : 0)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_OPS*WIDTH-1:0] in_ops,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SUM_W-1:0]       out_sum
);

   logic [OUT_W-1:0] cs_s;
   logic [OUT_W-1:0] cs_c;
   logic [OUT_W-1:0] op;

   logic             s1_valid;
   logic [OUT_W-1:0] s1_sum;
   logic [OUT_W-1:0] s1_carry;
   logic [OUT_W-1:0] beat;
   logic             out_load;

   // Carry truncation at OUT_W is harmless: the true total always fits.
   always_comb begin
      cs_s = OUT_W'(in_ops[0 +: WIDTH]);
      cs_c = OUT_W'(in_ops[WIDTH +: WIDTH]);
      op   = '0;
      for (int k = 2; k < N_OPS; k++) begin
         op   = OUT_W'(in_ops[k*WIDTH +: WIDTH]);
         {cs_s, cs_c} = {cs_s ^ cs_c ^ op,
                         ((cs_s & cs_c) | (cs_s & op) | (cs_c & op)) << 1};
      end
   end

   assign out_load = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || out_load;
   assign beat     = s1_sum + s1_carry;

`ifdef MOA_ACCUM_EN
   logic             s1_last;
   logic [SUM_W-1:0] acc;
   logic [SUM_W-1:0] total;

   assign total = acc + SUM_W'(beat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_sum   <= '0;
         s1_carry <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_last  <= in_last;
            s1_sum   <= cs_s;
            s1_carry <= cs_c;
         end
      end
   end

   // Non-last beats fold into acc; the last one publishes and clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         acc       <= '0;
      end else if (out_load) begin
         out_valid <= s1_last;
         if (s1_last) begin
            out_sum <= total;
            acc     <= '0;
         end else begin
            acc     <= total;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`else
   logic unused_last;

   assign unused_last = in_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_carry <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sum   <= cs_s;
            s1_carry <= cs_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
      end else if (out_load) begin
         out_valid <= 1'b1;
         out_sum   <= beat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule
